// File: rtl/bridge_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bridge_bus_arbiter_if
//
// Bundles everything that passes between the two bus masters, the arbiter and
// the Bridge data port.
//
//   Master M0 / M1 (x = 0, 1):
//     mx_req    request, held high until mx_ack
//     mx_wr     1 = write, 0 = read
//     mx_addr   byte address
//     mx_wdata  write data
//     mx_ack    one-cycle completion pulse
//     mx_err    error flag, valid with mx_ack
//     mx_rdata  read data, valid with mx_ack
//   Bridge side:
//     bus_addr  to Bridge Addr
//     bus_wdata to Bridge DMWD
//     bus_wr    to Bridge DMWr
//     bus_rdata from Bridge DMRD
//   Status:
//     grant     one-hot bus owner, bit0 = M0
//     busy      high while a transaction is in progress
//
// Modports:
//   slave  - the arbiter, which serves the masters and drives the Bridge
//   master - the masters together with the Bridge read-data source
// ---------------------------------------------------------------------------
interface bridge_bus_arbiter_if;

  logic        m0_req;
  logic        m0_wr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_wr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic [31:0] bus_rdata;

  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  bus_rdata,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output bus_addr, bus_wdata, bus_wr,
    output grant, busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output bus_rdata,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  bus_addr, bus_wdata, bus_wr,
    input  grant, busy
  );

endinterface

// File: rtl/bridge_bus_arbiter.sv
// ---------------------------------------------------------------------------
// bridge_bus_arbiter
//
// Shares the single Bridge data port between M0 (CPU MEM stage) and M1
// (DMA / debug loader). One request is latched at a time, driven onto the
// Bridge for a region-dependent number of cycles, completed with a single
// write strobe (writes only) and acknowledged for one cycle. Ownership
// alternates round-robin under contention. Writes into the IM window never
// reach the Bridge and come back with err set.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous reset, active-low
//   bus      bridge_bus_arbiter_if.slave (master handshakes, Bridge port,
//            grant and busy)
//
// Parameters:
//   DM_WAIT   extra access cycles, DM window  (addr[15:12] = 0..2)
//   IM_WAIT   extra access cycles, IM window  (addr[15:12] = 3..4)
//   DEV_WAIT  extra access cycles, everything else (timers included)
//   WAIT_W    wait counter width; every *_WAIT must fit in it
// ---------------------------------------------------------------------------
module bridge_bus_arbiter #(
  parameter int DM_WAIT  = 0,
  parameter int DEV_WAIT = 2,
  parameter int IM_WAIT  = 1,
  parameter int WAIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bridge_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REGION_DM,
    REGION_IM,
    REGION_DEV
  } region_t;

  localparam logic [WAIT_W-1:0] DM_CYCLES  = WAIT_W'(DM_WAIT);
  localparam logic [WAIT_W-1:0] IM_CYCLES  = WAIT_W'(IM_WAIT);
  localparam logic [WAIT_W-1:0] DEV_CYCLES = WAIT_W'(DEV_WAIT);

  // Owner / last_served encoding: 0 = M0, 1 = M1.
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  state_t            state;
  state_t            next_state;

  logic              owner;
  logic              last_served;

  logic              lat_wr;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  region_t           lat_region;
  logic [WAIT_W-1:0] wait_cnt;

  logic [31:0]       m0_rdata_q;
  logic              m0_err_q;
  logic [31:0]       m1_rdata_q;
  logic              m1_err_q;

  logic              pick_valid;
  logic              pick_m1;
  logic              sel_wr;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  region_t           sel_region;
  logic [WAIT_W-1:0] sel_wait;

  logic              final_cycle;
  logic              im_write;

  // Only the 4 KiB page number matters for decoding; the upper half-word is
  // deliberately ignored so aliases of the windows decode identically.
  function automatic region_t decode_region(input logic [3:0] page);
    region_t r;
    if (page <= 4'd2) begin
      r = REGION_DM;
    end else if (page <= 4'd4) begin
      r = REGION_IM;
    end else begin
      r = REGION_DEV;
    end
    return r;
  endfunction

  function automatic logic [WAIT_W-1:0] region_wait(input region_t r);
    logic [WAIT_W-1:0] w;
    case (r)
      REGION_DM: w = DM_CYCLES;
      REGION_IM: w = IM_CYCLES;
      default:   w = DEV_CYCLES;
    endcase
    return w;
  endfunction

  // Round-robin pick among the sampled requests. With both masters asking,
  // the one that was not served last wins; a lone requester always wins.
  // The winner's fields are muxed here so IDLE can latch them in one step.
  always_comb begin
    pick_valid = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      pick_m1 = (last_served == OWNER_M0);
    end else begin
      pick_m1 = bus.m1_req;
    end
    sel_wr     = pick_m1 ? bus.m1_wr    : bus.m0_wr;
    sel_addr   = pick_m1 ? bus.m1_addr  : bus.m0_addr;
    sel_wdata  = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
    sel_region = decode_region(sel_addr[15:12]);
    sel_wait   = region_wait(sel_region);
  end

  assign final_cycle = (state == ACCESS) && (wait_cnt == '0);
  assign im_write    = lat_wr && (lat_region == REGION_IM);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. The write strobe is only possible on
  // the last ACCESS cycle, which the counter guarantees happens exactly once
  // per transaction.
  always_comb begin
    next_state  = state;
    bus.bus_wr  = 1'b0;
    bus.grant   = 2'b00;
    bus.busy    = 1'b0;
    bus.m0_ack  = 1'b0;
    bus.m1_ack  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        bus.grant = (owner == OWNER_M1) ? 2'b10 : 2'b01;
        bus.busy  = 1'b1;
        if (wait_cnt == '0) begin
          bus.bus_wr = lat_wr && (lat_region != REGION_IM);
          next_state = RESP;
        end
      end
      RESP: begin
        bus.grant  = (owner == OWNER_M1) ? 2'b10 : 2'b01;
        bus.busy   = 1'b1;
        bus.m0_ack = (owner == OWNER_M0);
        bus.m1_ack = (owner == OWNER_M1);
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch. Captured only on the IDLE->ACCESS transition, so a master
  // that drops req or changes its fields mid-transaction has no effect on
  // what the Bridge sees.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= OWNER_M0;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_region <= REGION_DM;
    end else if (state == IDLE && pick_valid) begin
      owner      <= pick_m1;
      lat_wr     <= sel_wr;
      lat_addr   <= sel_addr;
      lat_wdata  <= sel_wdata;
      lat_region <= sel_region;
    end
  end

  // Wait counter: loaded in IDLE, counts down in ACCESS and parks at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE && pick_valid) begin
      wait_cnt <= sel_wait;
    end else if (state == ACCESS && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

  // Fairness memory. Reset to M1 so M0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_served <= OWNER_M1;
    end else if (state == RESP) begin
      last_served <= owner;
    end
  end

  // Per-master response registers. Loaded on the final ACCESS cycle so they
  // are valid during the ack cycle, then held until that master's next ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_rdata_q <= '0;
      m1_err_q   <= 1'b0;
    end else if (final_cycle) begin
      if (owner == OWNER_M0) begin
        m0_rdata_q <= lat_wr ? 32'h0 : bus.bus_rdata;
        m0_err_q   <= im_write;
      end else begin
        m1_rdata_q <= lat_wr ? 32'h0 : bus.bus_rdata;
        m1_err_q   <= im_write;
      end
    end
  end

  // The latched request drives the Bridge directly, which keeps address and
  // data stable through ACCESS and RESP and zero after reset.
  assign bus.bus_addr  = lat_addr;
  assign bus.bus_wdata = lat_wdata;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.m1_err    = m1_err_q;

endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bridge_bus_arbiter
//
// Scoreboard bench for bridge_bus_arbiter. Each master request pushes its
// expected response (and, for non-IM writes, its expected Bridge strobe)
// into queues computed from the address map; a negedge monitor pops them
// whenever an ack or a write strobe appears and also enforces round-robin
// order and the idle cycle after every ack.
// ---------------------------------------------------------------------------
module tb_bridge_bus_arbiter;

  localparam int DM_WAIT  = 0;
  localparam int DEV_WAIT = 2;
  localparam int IM_WAIT  = 1;
  localparam int WAIT_W   = 4;
  localparam int TIMEOUT  = 80;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          issue;
    int          expLat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  resp_t respQ0[$];
  resp_t respQ1[$];
  wr_t   wrQ0[$];
  wr_t   wrQ1[$];
  int    reqSince[2];
  int    lastAckM;
  int    lastAckCycle;

  bridge_bus_arbiter_if bif();

  bridge_bus_arbiter #(
    .DM_WAIT (DM_WAIT),
    .DEV_WAIT(DEV_WAIT),
    .IM_WAIT (IM_WAIT),
    .WAIT_W  (WAIT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Bridge read data: a fixed function of the address.
  function automatic logic [31:0] bridgeData(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb bif.bus_rdata = bridgeData(bif.bus_addr);

  // Address map, expressed as byte ranges of the low half-word.
  function automatic bit modelIsIm(input logic [31:0] a);
    logic [31:0] off;
    off = a & 32'h0000_FFFF;
    return (off >= 32'h3000) && (off < 32'h5000);
  endfunction

  function automatic int modelWait(input logic [31:0] a);
    logic [31:0] off;
    off = a & 32'h0000_FFFF;
    if (off < 32'h3000) return DM_WAIT;
    if (off < 32'h5000) return IM_WAIT;
    return DEV_WAIT;
  endfunction

  function automatic logic ackOf(input int m);
    return (m == 0) ? bif.m0_ack : bif.m1_ack;
  endfunction

  function automatic logic errOf(input int m);
    return (m == 0) ? bif.m0_err : bif.m1_err;
  endfunction

  function automatic logic [31:0] rdataOf(input int m);
    return (m == 0) ? bif.m0_rdata : bif.m1_rdata;
  endfunction

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, exp, cycle);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s %s cycle=%0d", name, what, cycle);
  endtask

  task automatic driveMaster(input int m, input logic req, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      bif.m0_req = req; bif.m0_wr = wr; bif.m0_addr = addr; bif.m0_wdata = wdata;
    end else begin
      bif.m1_req = req; bif.m1_wr = wr; bif.m1_addr = addr; bif.m1_wdata = wdata;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    compareValue({tag, "_bus_addr"},  bif.bus_addr, 32'h0);
    compareValue({tag, "_bus_wdata"}, bif.bus_wdata, 32'h0);
    compareValue({tag, "_bus_wr"},    32'(bif.bus_wr), 32'h0);
    compareValue({tag, "_grant"},     32'(bif.grant), 32'h0);
    compareValue({tag, "_busy"},      32'(bif.busy), 32'h0);
    compareValue({tag, "_m0_ack"},    32'(bif.m0_ack), 32'h0);
    compareValue({tag, "_m0_err"},    32'(bif.m0_err), 32'h0);
    compareValue({tag, "_m0_rdata"},  bif.m0_rdata, 32'h0);
    compareValue({tag, "_m1_ack"},    32'(bif.m1_ack), 32'h0);
    compareValue({tag, "_m1_err"},    32'(bif.m1_err), 32'h0);
    compareValue({tag, "_m1_rdata"},  bif.m1_rdata, 32'h0);
  endtask

  // One transaction for master m. Must be called just after a rising edge;
  // returns just after the rising edge that ends the ack cycle, req low.
  task automatic applyStimulus(input int m, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit dropEarly,
                               input bit solo, output int ackCycle);
    resp_t r;
    wr_t   w;
    bit    got;
    bit    granted;
    bit    checkAddr;
    r.rdata  = wr ? 32'h0 : bridgeData(addr);
    r.err    = wr && modelIsIm(addr);
    r.issue  = cycle;
    r.expLat = solo ? (2 + modelWait(addr)) : -1;
    if (m == 0) respQ0.push_back(r); else respQ1.push_back(r);
    if (wr && !modelIsIm(addr)) begin
      w.addr  = addr;
      w.wdata = wdata;
      if (m == 0) wrQ0.push_back(w); else wrQ1.push_back(w);
    end
    reqSince[m] = cycle;
    driveMaster(m, 1'b1, wr, addr, wdata);
    checkAddr = 1'b0;
    if (dropEarly) begin
      granted = 1'b0;
      for (int n = 0; n < TIMEOUT && !granted; n++) begin
        @(negedge clk);
        if (bif.grant[m]) granted = 1'b1;
      end
      if (!granted) failNow("grant_timeout", $sformatf("M%0d never granted", m));
      @(posedge clk); #1;
      driveMaster(m, 1'b0, ~wr, ~addr, $urandom);
      checkAddr = 1'b1;
    end
    got = 1'b0;
    ackCycle = -1;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(negedge clk);
      if (checkAddr && bif.grant[m]) begin
        compareValue("held_bus_addr", bif.bus_addr, addr);
        checkAddr = 1'b0;
      end
      if (ackOf(m)) begin
        got = 1'b1;
        ackCycle = cycle;
        break;
      end
    end
    if (!got) failNow("ack_timeout", $sformatf("M%0d no ack within %0d cycles", m, TIMEOUT));
    @(posedge clk); #1;
    driveMaster(m, 1'b0, wr, addr, wdata);
  endtask

  // Monitor body: pops the scoreboard on acks and write strobes.
  task automatic checkOutput();
    resp_t r;
    wr_t   w;
    int    x;
    if (!reset_n) return;
    if (cycle == lastAckCycle + 1) begin
      compareValue("idle_after_ack_busy", 32'(bif.busy), 32'h0);
      compareValue("idle_after_ack_grant", 32'(bif.grant), 32'h0);
    end
    if (bif.m0_ack && bif.m1_ack) failNow("double_ack", "both acks high, required one");
    for (int m = 0; m < 2; m++) begin
      if (ackOf(m)) begin
        if ((m == 0 && respQ0.size() == 0) || (m == 1 && respQ1.size() == 0)) begin
          failNow("unexpected_ack", $sformatf("M%0d ack with nothing outstanding", m));
        end else begin
          r = (m == 0) ? respQ0.pop_front() : respQ1.pop_front();
          compareValue($sformatf("m%0d_rdata", m), rdataOf(m), r.rdata);
          compareValue($sformatf("m%0d_err", m), 32'(errOf(m)), 32'(r.err));
          if (r.expLat >= 0) compareValue($sformatf("m%0d_latency", m), 32'(cycle - r.issue), 32'(r.expLat));
          checks++;
          if (lastAckM == m && reqSince[1-m] >= 0 && reqSince[1-m] <= lastAckCycle + 1) begin
            errors++;
            $display("[TB] FAIL rr_order served M%0d twice, required M%0d (waiting since cycle %0d)", m, 1-m, reqSince[1-m]);
          end
          lastAckM     = m;
          lastAckCycle = cycle;
          reqSince[m]  = -1;
        end
      end
    end
    if (bif.bus_wr) begin
      x = -1;
      if (bif.grant == 2'b01) x = 0;
      else if (bif.grant == 2'b10) x = 1;
      if (x < 0) begin
        failNow("write_grant", $sformatf("bus_wr with grant=%b, required one-hot", bif.grant));
      end else if ((x == 0 && wrQ0.size() == 0) || (x == 1 && wrQ1.size() == 0)) begin
        failNow("unexpected_bus_wr", $sformatf("strobe addr=0x%08h for M%0d, required none", bif.bus_addr, x));
      end else begin
        w = (x == 0) ? wrQ0.pop_front() : wrQ1.pop_front();
        compareValue("strobe_addr", bif.bus_addr, w.addr);
        compareValue("strobe_wdata", bif.bus_wdata, w.wdata);
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  // Watches one uncontended transaction issued this cycle: grant/address
  // for every ACCESS cycle, then RESP, then back to idle.
  task automatic watchGrant(input int m, input logic [31:0] addr);
    logic [1:0] g;
    g = (m == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    compareValue("pre_grant", 32'(bif.grant), 32'h0);
    repeat (modelWait(addr) + 1) begin
      @(negedge clk);
      compareValue("access_grant", 32'(bif.grant), 32'(g));
      compareValue("access_bus_addr", bif.bus_addr, addr);
    end
    @(negedge clk);
    compareValue("resp_grant", 32'(bif.grant), 32'(g));
    compareValue("resp_busy", 32'(bif.busy), 32'h1);
  endtask

  task automatic randomMaster(input int m, input int count);
    int          ac;
    logic [31:0] a;
    logic        wr;
    for (int i = 0; i < count; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a[15:12] = 4'($urandom_range(0, 2));
        1: a[15:12] = 4'($urandom_range(3, 4));
        2: a[15:0]  = 16'h7F00 + 16'($urandom_range(0, 31));
        default: a[15:12] = 4'($urandom_range(5, 15));
      endcase
      wr = 1'($urandom_range(0, 1));
      applyStimulus(m, wr, a, $urandom, ($urandom_range(0, 7) == 0), 1'b0, ac);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic backToBack(input int m, input int count);
    int ac;
    for (int i = 0; i < count; i++) begin
      applyStimulus(m, 1'b0, 32'h0000_0100 + 32'(m * 16 + i * 4), 32'h0, 1'b0, 1'b0, ac);
    end
  endtask

  initial begin
    int ac;
    bit got;
    reset_n      = 1'b0;
    driveMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
    driveMaster(1, 1'b0, 1'b0, 32'h0, 32'h0);
    reqSince[0]  = -1;
    reqSince[1]  = -1;
    lastAckM     = 1;
    lastAckCycle = -10;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset_n = 1'b1;
    lastAckCycle = cycle - 1;
    @(posedge clk); #1;

    $display("[TB] DM read, DEV write, IM write/read");
    fork
      applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, ac);
      watchGrant(0, 32'h0000_0010);
    join
    fork
      applyStimulus(1, 1'b1, 32'h0000_7F04, 32'h0000_0064, 1'b0, 1'b1, ac);
      watchGrant(1, 32'h0000_7F04);
    join
    applyStimulus(0, 1'b1, 32'h0000_3010, 32'h1234_5678, 1'b0, 1'b1, ac);
    applyStimulus(0, 1'b0, 32'h0000_3010, 32'h0, 1'b0, 1'b1, ac);

    $display("[TB] M1 drops req mid-access while M0 waits");
    fork
      applyStimulus(1, 1'b1, 32'h0000_7F10, 32'h0000_CAFE, 1'b1, 1'b1, ac);
      begin
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 32'h0001_2040, 32'h0, 1'b0, 1'b0, ac);
      end
    join

    $display("[TB] continuous contention");
    fork
      backToBack(0, 4);
      backToBack(1, 4);
    join

    $display("[TB] randomized traffic");
    fork
      randomMaster(0, 40);
      randomMaster(1, 40);
    join

    $display("[TB] reset during an M0 write");
    driveMaster(0, 1'b1, 1'b1, 32'h0000_7F00, 32'h0000_0077);
    got = 1'b0;
    for (int n = 0; n < TIMEOUT && !got; n++) begin
      @(negedge clk);
      if (bif.grant[0]) got = 1'b1;
    end
    if (!got) failNow("midreset_grant", "M0 write never granted");
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    driveMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reqSince[0]  = -1;
    reqSince[1]  = -1;
    lastAckM     = 1;
    lastAckCycle = cycle - 1;
    reset_n      = 1'b1;
    fork
      applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b0, ac);
      applyStimulus(1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, ac);
    join

    repeat (5) @(posedge clk);
    #1;
    compareValue("leftover_responses", 32'(respQ0.size() + respQ1.size()), 32'h0);
    compareValue("leftover_writes", 32'(wrQ0.size() + wrQ1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
